rtc_bus_sequencer: RTL

Parametrised bus-cycle engine for multiplexed address/data RTC chips, succeeding the fixed single-register read/write cycle blocks. One `start` runs a burst of 1..BURST_MAX register transfers, read or write, with optional address auto-increment. Each transfer is an address phase followed by a data phase, with programmable strobe and recovery widths. The block sits between the PicoBlaze port registers and the top-level `AddressData` inout, which is built from `ad_out`, `ad_oe` and `ad_in`.

---
 rtl/rtc_bus_sequencer_if.sv | 34 +++
 rtl/rtc_bus_sequencer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_sequencer_if.sv
// Host-side burst request/response and pad-side signals of the RTC bus sequencer.
interface rtc_bus_sequencer_if #(
  parameter int BUS_W = 8,
  parameter int CNT_W = 5
);
  logic             start;
  logic             rw;
  logic             inc;
  logic [BUS_W-1:0] base_addr;
  logic [CNT_W-1:0] count;
  logic [BUS_W-1:0] wr_data;
  logic             wr_ack;
  logic [BUS_W-1:0] rd_data;
  logic             rd_valid;
  logic [BUS_W-1:0] ad_in;
  logic [BUS_W-1:0] ad_out;
  logic             ad_oe;
  logic             ad;
  logic             cs_n;
  logic             rd_n;
  logic             wr_n;
  logic             busy;
  logic             done;

  modport master (
    input  start, rw, inc, base_addr, count, wr_data, ad_in,
    output wr_ack, rd_data, rd_valid, ad_out, ad_oe, ad, cs_n, rd_n, wr_n, busy, done
  );

  modport slave (
    output start, rw, inc, base_addr, count, wr_data, ad_in,
    input  wr_ack, rd_data, rd_valid, ad_out, ad_oe, ad, cs_n, rd_n, wr_n, busy, done
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Burst engine for multiplexed address/data RTC chips: address strobe, gap,
// data strobe and recovery per beat, with all pad-facing outputs registered.
module rtc_bus_sequencer #(
  parameter int BUS_W     = 8,
  parameter int BURST_MAX = 16,
  parameter int CNT_W     = 5,
  parameter int T_ADDR    = 2,
  parameter int T_GAP     = 1,
  parameter int T_DATA    = 3,
  parameter int T_REC     = 2
) (
  input  logic                clock,
  input  logic                reset,
  rtc_bus_sequencer_if.master bus
);

  localparam int TMAX_AG = (T_ADDR > T_GAP) ? T_ADDR : T_GAP;
  localparam int TMAX_DR = (T_DATA > T_REC) ? T_DATA : T_REC;
  localparam int TMAX    = (TMAX_AG > TMAX_DR) ? TMAX_AG : TMAX_DR;
  localparam int PH_W    = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [CNT_W-1:0] BMAX = CNT_W'(BURST_MAX);

  typedef enum logic [2:0] {IDLE, A_STB, A_REC, D_STB, D_REC, FIN} state_t;

  state_t           state_q;
  logic [PH_W-1:0]  ph_q;
  logic [CNT_W-1:0] beats_q;
  logic [BUS_W-1:0] addr_q;
  logic             rw_q, inc_q;
  logic             cs_n_q, rd_n_q, wr_n_q, ad_q, ad_oe_q;
  logic [BUS_W-1:0] ad_out_q, rd_data_q;
  logic             rd_valid_q, wr_ack_q, busy_q, done_q;

  logic [CNT_W-1:0] eff_cnt_d;
  logic [BUS_W-1:0] addr_d;

  function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] c);
    return (c > BMAX) ? BMAX : c;
  endfunction

  assign eff_cnt_d = sat_count(bus.count);
  assign addr_d    = inc_q ? addr_q + BUS_W'(1) : addr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      ph_q       <= '0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      ad_q       <= 1'b1;
      ad_oe_q    <= 1'b0;
      ad_out_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            rw_q    <= bus.rw;
            inc_q   <= bus.inc;
            addr_q  <= bus.base_addr;
            beats_q <= eff_cnt_d;
            if (eff_cnt_d == '0) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= A_STB;
              ph_q     <= PH_W'(T_ADDR - 1);
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              cs_n_q   <= 1'b0;
              ad_q     <= 1'b0;
              wr_n_q   <= 1'b0;
              ad_oe_q  <= 1'b1;
              ad_out_q <= bus.base_addr;
            end
          end
        end
        A_STB: begin
          if (ph_q == '0) begin
            state_q <= A_REC;
            ph_q    <= PH_W'(T_GAP - 1);
            ad_q    <= 1'b1;
            wr_n_q  <= 1'b1;
          end else begin
            ph_q <= ph_q - PH_W'(1);
          end
        end
        A_REC: begin
          if (ph_q == '0) begin
            state_q <= D_STB;
            ph_q    <= PH_W'(T_DATA - 1);
            // Write data is taken at the last gap cycle so it is stable for the whole data strobe.
            if (rw_q) begin
              ad_out_q <= bus.wr_data;
              wr_ack_q <= 1'b1;
              wr_n_q   <= 1'b0;
            end else begin
              rd_n_q  <= 1'b0;
              ad_oe_q <= 1'b0;
            end
          end else begin
            ph_q <= ph_q - PH_W'(1);
          end
        end
        D_STB: begin
          if (ph_q == '0) begin
            state_q <= D_REC;
            ph_q    <= PH_W'(T_REC - 1);
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            ad_oe_q <= 1'b0;
            if (!rw_q) begin
              rd_data_q  <= bus.ad_in;
              rd_valid_q <= 1'b1;
            end
          end else begin
            ph_q <= ph_q - PH_W'(1);
          end
        end
        D_REC: begin
          if (ph_q == '0) begin
            addr_q  <= addr_d;
            beats_q <= beats_q - CNT_W'(1);
            if (beats_q == CNT_W'(1)) begin
              state_q <= FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q  <= A_STB;
              ph_q     <= PH_W'(T_ADDR - 1);
              cs_n_q   <= 1'b0;
              ad_q     <= 1'b0;
              wr_n_q   <= 1'b0;
              ad_oe_q  <= 1'b1;
              ad_out_q <= addr_d;
            end
          end else begin
            ph_q <= ph_q - PH_W'(1);
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cs_n     = cs_n_q;
  assign bus.rd_n     = rd_n_q;
  assign bus.wr_n     = wr_n_q;
  assign bus.ad       = ad_q;
  assign bus.ad_oe    = ad_oe_q;
  assign bus.ad_out   = ad_out_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
